// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code run controller.
package gray_pkg;

  localparam int GRAY_WIDTH = 4;
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Callers zero-extend narrower positions; high zero bits do not disturb the code.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_run_ctrl_if.sv
// Step-command handshake between a command source and the Gray run controller.
interface gray_run_ctrl_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_len;
  logic             cmd_dir;
  logic             cmd_clr;

  modport master (output cmd_valid, output cmd_len, output cmd_dir, output cmd_clr,
                  input cmd_ready);
  modport slave  (input cmd_valid, input cmd_len, input cmd_dir, input cmd_clr,
                  output cmd_ready);
endinterface

// File: rtl/gray_core.sv
// Binary position register with registered Gray-code view and step strobe.
module gray_core
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             up_i,
  input  logic             dn_i,
  output logic [WIDTH-1:0] gray_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;

  // Clear wins over stepping; a clear reloads the code without a valid strobe.
  always_comb begin
    pos_d   = pos_q;
    gray_d  = gray_q;
    valid_d = 1'b0;
    if (clr_i) begin
      pos_d  = {WIDTH{1'b0}};
      gray_d = {WIDTH{1'b0}};
    end else if (up_i) begin
      pos_d   = pos_q + WIDTH'(1);
      gray_d  = WIDTH'(bin2gray(GRAY_MAX_W'(pos_d)));
      valid_d = 1'b1;
    end else if (dn_i) begin
      pos_d   = pos_q - WIDTH'(1);
      gray_d  = WIDTH'(bin2gray(GRAY_MAX_W'(pos_d)));
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Position, code and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= {WIDTH{1'b0}};
      gray_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
    end
  end

  assign gray_o  = gray_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/gray_run_ctrl.sv
// Command sequencer: accepts step commands and drives the Gray position core.
module gray_run_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  gray_run_ctrl_if.slave   cmd,
  input  logic             pause_i,
  output logic [WIDTH-1:0] gray_out_o,
  output logic             gray_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             clr_s, up_s, dn_s;

  // Next-state, remaining-step count and core step controls.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    clr_s   = 1'b0;
    up_s    = 1'b0;
    dn_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          rem_d   = cmd.cmd_len;
          dir_d   = cmd.cmd_dir;
          clr_s   = cmd.cmd_clr;
          state_d = (cmd.cmd_len != {WIDTH{1'b0}}) ? RUN : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!pause_i) begin
          up_s  = dir_q;
          dn_s  = ~dir_q;
          rem_d = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, remaining count and latched direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= {WIDTH{1'b0}};
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  gray_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr_s),
    .up_i    (up_s),
    .dn_i    (dn_s),
    .gray_o  (gray_out_o),
    .valid_o (gray_valid_o)
  );

  // Handshake and status come straight off the state register.
  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Bench for gray_run_ctrl: directed table plus randomized commands against a trace model.
module tb_gray_run_ctrl;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         pause_i;
  logic [W-1:0] gray_out_o;
  logic         gray_valid_o, busy_o, done_o;

  gray_run_ctrl_if #(.WIDTH(W)) cmd_if ();

  gray_run_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd_if.slave),
    .pause_i      (pause_i),
    .gray_out_o   (gray_out_o),
    .gray_valid_o (gray_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pos_m  = 0;

  typedef struct {
    int          len;
    bit          dir;
    bit          clr;
    logic [15:0] pmask;
    bit          hold;
    int          exp_gray;
    int          exp_done;
    int          exp_pulses;
    logic [15:0] exp_seq;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gray_of(input int p);
    return p ^ (p >> 1);
  endfunction

  // Issues one command and follows it cycle by cycle: steps land on each unpaused edge
  // until len steps are taken; done follows the last step, ready one cycle after that.
  task automatic run_cmd(input int len, input bit dir, input bit clr, input logic [15:0] pmask,
                         input bit hold, input bit idle_pause,
                         output int last_gray, output int done_cyc, output int pulses,
                         output logic [15:0] seq);
    int  steps = 0;
    int  c_last = -1;
    int  prev_g;
    bit  finished = 0;
    chk("ready_before_accept", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_len   = W'(len);
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_clr   = clr;
    pause_i          = idle_pause;
    tick();
    if (clr) pos_m = 0;
    if (len == 0) c_last = 0;
    pulses   = 0;
    done_cyc = -1;
    seq      = 16'h0000;
    chk("accept_gray", gray_out_o, gray_of(pos_m));
    chk("accept_gvalid", gray_valid_o, 0);
    chk("accept_busy", busy_o, 1);
    chk("accept_ready", cmd_if.cmd_ready, 0);
    chk("accept_done", done_o, (len == 0));
    if (done_o) done_cyc = 1;
    if (hold) begin
      cmd_if.cmd_len = ~W'(len);
      cmd_if.cmd_dir = ~dir;
      cmd_if.cmd_clr = 1'b1;
    end else begin
      cmd_if.cmd_valid = 1'b0;
    end
    prev_g = gray_of(pos_m);
    for (int c = 1; c <= 64 && !finished; c++) begin
      bit p, stepped, act;
      p = (c <= 16) ? pmask[c-1] : 1'b0;
      if (c_last >= 0) cmd_if.cmd_valid = 1'b0;
      pause_i = p;
      tick();
      stepped = (c_last < 0) && !p;
      if (stepped) begin
        pos_m = dir ? (pos_m + 1) % MOD : (pos_m + MOD - 1) % MOD;
        steps++;
        if (steps == len) c_last = c;
      end
      act = (c_last < 0) || (c <= c_last);
      chk("run_gray", gray_out_o, gray_of(pos_m));
      chk("run_gvalid", gray_valid_o, stepped);
      chk("run_done", done_o, (c == c_last));
      chk("run_busy", busy_o, act);
      chk("run_ready", cmd_if.cmd_ready, !act);
      if (gray_valid_o) begin
        pulses++;
        if (pulses <= 4) seq[(pulses-1)*4 +: 4] = gray_out_o;
        chk("single_bit_change", $countones(gray_out_o ^ W'(prev_g)), 1);
        prev_g = gray_out_o;
      end
      if (done_o) done_cyc = c + 1;
      if (c_last >= 0 && c == c_last + 1) finished = 1;
    end
    if (!finished) chk("run_cycle_budget", 0, 1);
    last_gray        = gray_out_o;
    pause_i          = 1'b0;
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    int          lg, dc, np;
    logic [15:0] sq;

    tbl[0] = '{3,  1'b1, 1'b1, 16'h0000, 1'b0, 2, 4,  3,  16'h0231};
    tbl[1] = '{11, 1'b1, 1'b0, 16'h0000, 1'b0, 9, 12, 11, 16'h4576};
    tbl[2] = '{3,  1'b1, 1'b0, 16'h0000, 1'b0, 1, 4,  3,  16'h0108};
    tbl[3] = '{2,  1'b0, 1'b0, 16'h0000, 1'b0, 8, 3,  2,  16'h0080};
    tbl[4] = '{0,  1'b1, 1'b0, 16'h0000, 1'b0, 8, 1,  0,  16'h0000};
    tbl[5] = '{4,  1'b1, 1'b0, 16'h0006, 1'b1, 2, 7,  4,  16'h2310};
    tbl[6] = '{15, 1'b0, 1'b1, 16'h0000, 1'b0, 1, 16, 15, 16'hAB98};

    rst              = 1'b1;
    pause_i          = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_len   = '0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_clr   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_ready", cmd_if.cmd_ready, 1);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_gvalid", gray_valid_o, 0);
    chk("reset_gray", gray_out_o, 0);

    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i].len, tbl[i].dir, tbl[i].clr, tbl[i].pmask, tbl[i].hold, 1'b0,
              lg, dc, np, sq);
      chk($sformatf("tbl%0d_final_gray", i), lg, tbl[i].exp_gray);
      chk($sformatf("tbl%0d_done_cycle", i), dc, tbl[i].exp_done);
      chk($sformatf("tbl%0d_pulses", i), np, tbl[i].exp_pulses);
      chk($sformatf("tbl%0d_gray_seq", i), sq, tbl[i].exp_seq);
    end

    // Reset after the second step of a five-step run aborts without done.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_len   = W'(5);
    cmd_if.cmd_dir   = 1'b1;
    cmd_if.cmd_clr   = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    tick();
    chk("abort_pre_gray", gray_out_o, 4'b0011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pos_m = 0;
    chk("abort_gray", gray_out_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_ready", cmd_if.cmd_ready, 1);
    chk("abort_done", done_o, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_done", done_o, 0);
    end

    for (int r = 0; r < 30; r++) begin
      run_cmd($urandom_range(0, MOD - 1), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              16'($urandom & $urandom), 1'($urandom), 1'($urandom), lg, dc, np, sq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_run_ctrl.md
# gray_run_ctrl

Sequencer for the team's Gray-code counter datapath. It accepts step commands over a valid/ready handshake, advances a binary position register up or down by the commanded number of steps, and presents each position as registered Gray code. It reports completion with a one-cycle `done`. It sits between a command source (CPU register block or test sequencer) and logic that consumes single-bit-change codes, such as encoder emulation or CDC pointers.

## Interface
- `WIDTH`, default 4: counter width; position and Gray code both `WIDTH` bits.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_len`  in  WIDTH  number of steps to run, 0 to 2^WIDTH-1.
- `cmd_dir`  in  1  1 = count up, 0 = count down.
- `cmd_clr`  in  1  reset position to 0 when the command is accepted.
- `pause`  in  1  hold: no step in RUN while high.
- `gray_out`  out  WIDTH  registered Gray code of the current position.
- `gray_valid`  out  1  one-cycle pulse in the cycle after each step, when `gray_out` holds a new code.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse marking command completion.

## Operation
- State machine: IDLE, RUN, DONE.
- Accept: `cmd_valid && cmd_ready` in IDLE.
  - Loads `rem <= cmd_len` and latches the direction.
  - If `cmd_clr` is set: `pos <= 0` and `gray_out <= 0`, with no `gray_valid` pulse.
  - Next state is RUN if `cmd_len != 0`, otherwise DONE.
- RUN with `pause=0` performs one step:
  - `pos <= pos ± 1`, modulo 2^WIDTH.
  - `gray_out <= g(pos ± 1)`, where g(b) = b ^ (b >> 1).
  - `gray_valid <= 1` and `rem <= rem - 1`.
  - If `rem == 1`, next state is DONE.
- RUN with `pause=1`: no step, `gray_valid` goes low, all state held.
- DONE: `done=1` for exactly one cycle, then IDLE.
- Position persists across commands unless `cmd_clr` is set.
- Wrap-around:
  - Up from 2^WIDTH-1 goes to 0; for WIDTH=4, 1000 → 0000.
  - Down from 0 goes to 2^WIDTH-1; 0000 → 1000.
- Every consecutive `gray_out` change differs in exactly one bit, except the `cmd_clr` load.
- `cmd_valid` while busy is ignored; the source must hold the command until `cmd_ready` is seen.
- `cmd_dir`, `cmd_len` and `cmd_clr` are sampled only at accept.
- Reset values: state IDLE, `pos=0`, `rem=0`, `gray_out=0`, `gray_valid=0`, `done=0`, `busy=0`, `cmd_ready=1` (the cycle after `rst` deasserts).
- Reset mid-command aborts it immediately: no `done`, position returns to 0.

## Timing
- `cmd_ready` and `busy` are decoded from the state register only; there is no combinational path from inputs.
- Accept at edge T: RUN from T+1; first step at edge T+1; first `gray_valid` and new `gray_out` visible after T+1.
- An N-step command with no pause: `gray_valid` high in N consecutive cycles, `done` in cycle N+1 after accept, `cmd_ready` high again one cycle later.
- `cmd_len=0`: `done` one cycle after accept, no `gray_valid`.
- `pause` is sampled each RUN cycle and adds one cycle of latency per cycle asserted. Pause in IDLE or DONE has no effect.
- Maximum throughput: one command per N+2 cycles.

## Structure
- Package `gray_pkg`:
  - `state_t` enum (IDLE, RUN, DONE).
  - Function `bin2gray(logic [WIDTH-1:0])`.
  - `WIDTH` default constant.
- Sub-module `gray_core`:
  - Holds the position register with load-zero, step-up and step-down controls.
  - Provides registered Gray output and the `gray_valid` pulse.
- `gray_run_ctrl` holds the FSM, the `rem` counter and the handshake.

## Test plan
- Reset, then an up command with `cmd_len=3`, `cmd_clr=1`: `gray_out` steps 0001, 0011, 0010 on 3 consecutive `gray_valid` cycles; `done` 4 cycles after accept; `cmd_ready` returns 1 one cycle later.
- From position 14, an up command with `cmd_len=3`: `gray_out` sequence 1000, 0000, 0001 (wrap); each change is a single bit.
- From position 1, a down command with `cmd_len=2`: `gray_out` sequence 0000, 1000.
- `cmd_len=0`: `done` one cycle after accept, no `gray_valid`, `gray_out` unchanged.
- `cmd_len=4` with `pause` high for 2 cycles mid-run: exactly 4 `gray_valid` pulses, `done` 7 cycles after accept; `cmd_valid` held during RUN is not accepted.
- `rst` asserted after the 2nd step of a 5-step run: next cycle `gray_out=0`, `busy=0`, `cmd_ready=1`, and `done` never pulses.
